// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: glitch-filtered clock, 11-bit frame capture with
// start/stop/parity/timeout checks, feeding a first-word-fall-through byte FIFO.
module ps2_rx_fifo #(
  parameter int FILTER_LEN   = 8,
  parameter int TIMEOUT      = 100000,
  parameter int FIFO_DEPTH   = 4,
  parameter int CHECK_PARITY = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ps2d,
  input  logic                          ps2c,
  input  logic                          rx_en,
  input  logic                          rd_en,
  output logic [7:0]                    dout,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          rx_done_tick,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          timeout_err,
  output logic                          overflow
);

  localparam int TW = $clog2(TIMEOUT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, DATA, CHECK} state_t;

  // ---------------- clock filter and data synchroniser ----------------
  logic [FILTER_LEN-1:0] filt_reg;
  logic                  f_c, f_c_next, fall_edge;
  logic [1:0]            d_sync;
  logic                  d;

  always_comb begin
    f_c_next = f_c;
    if (&filt_reg)       f_c_next = 1'b1;
    else if (~|filt_reg) f_c_next = 1'b0;
  end

  assign fall_edge = f_c & ~f_c_next;
  assign d         = d_sync[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_reg <= '0;
      f_c      <= 1'b0;
      d_sync   <= 2'b11;
    end else begin
      filt_reg <= {ps2c, filt_reg[FILTER_LEN-1:1]};
      f_c      <= f_c_next;
      d_sync   <= {d_sync[0], ps2d};
    end
  end

  // ---------------- frame FSM ----------------
  state_t        state, state_n;
  logic [3:0]    n_reg, n_n;
  logic [TW-1:0] t_reg, t_n;
  logic [9:0]    b_reg, b_n;
  logic          push, pop;
  logic          rx_n, fe_n, pe_n, to_n, ov_n;

  assign pop = rd_en & ~empty;

  always_comb begin
    state_n = state;
    n_n     = n_reg;
    t_n     = t_reg;
    b_n     = b_reg;
    push    = 1'b0;
    rx_n    = 1'b0;
    fe_n    = 1'b0;
    pe_n    = 1'b0;
    to_n    = 1'b0;
    ov_n    = 1'b0;
    case (state)
      IDLE: begin
        if (fall_edge && rx_en && !d) begin
          state_n = DATA;
          n_n     = '0;
          t_n     = '0;
        end
      end
      DATA: begin
        // shifts data, parity and stop; stop lands in bit 9
        if (fall_edge) begin
          b_n = {d, b_reg[9:1]};
          n_n = n_reg + 4'd1;
          t_n = '0;
          if (n_reg == 4'd9) state_n = CHECK;
        end else if (t_reg == TW'(TIMEOUT - 1)) begin
          to_n    = 1'b1;
          state_n = IDLE;
        end else begin
          t_n = t_reg + 1'b1;
        end
      end
      CHECK: begin
        state_n = IDLE;
        if (!b_reg[9])                               fe_n = 1'b1;
        else if (CHECK_PARITY != 0 && !(^b_reg[8:0])) pe_n = 1'b1;
        else if (full && !pop)                        ov_n = 1'b1;
        else begin
          push = 1'b1;
          rx_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      n_reg        <= '0;
      t_reg        <= '0;
      b_reg        <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
      parity_err   <= 1'b0;
      timeout_err  <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      state        <= state_n;
      n_reg        <= n_n;
      t_reg        <= t_n;
      b_reg        <= b_n;
      rx_done_tick <= rx_n;
      frame_err    <= fe_n;
      parity_err   <= pe_n;
      timeout_err  <= to_n;
      overflow     <= ov_n;
    end
  end

  // ---------------- FWFT FIFO ----------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= b_reg[7:0];
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(FIFO_DEPTH));
  assign count = cnt;
  assign dout  = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboarded bench for ps2_rx_fifo: frames are bit-banged on ps2c/ps2d, expected
// bytes queued as sent and compared on FIFO reads; pulse outputs tallied per frame.
module tb_ps2_rx_fifo;
  localparam int TO = 2000, FL = 8, FD = 4;

  logic clk = 1'b0, reset = 1'b1, ps2d = 1'b1, ps2c = 1'b1, rx_en = 1'b1;
  logic rd_en = 1'b0, rd_en_np = 1'b0;

  logic [7:0] dout, np_dout;
  logic       empty, full, np_empty, np_full;
  logic [2:0] count, np_count;
  logic       rx_done_tick, frame_err, parity_err, timeout_err, overflow;
  logic       np_rx, np_fe, np_pe, np_to, np_ov;

  always #5 clk = ~clk;

  ps2_rx_fifo #(.FILTER_LEN(FL), .TIMEOUT(TO), .FIFO_DEPTH(FD), .CHECK_PARITY(1)) dut (
    .clk(clk), .reset(reset), .ps2d(ps2d), .ps2c(ps2c), .rx_en(rx_en), .rd_en(rd_en),
    .dout(dout), .empty(empty), .full(full), .count(count),
    .rx_done_tick(rx_done_tick), .frame_err(frame_err), .parity_err(parity_err),
    .timeout_err(timeout_err), .overflow(overflow));

  ps2_rx_fifo #(.FILTER_LEN(FL), .TIMEOUT(TO), .FIFO_DEPTH(FD), .CHECK_PARITY(0)) dut_np (
    .clk(clk), .reset(reset), .ps2d(ps2d), .ps2c(ps2c), .rx_en(rx_en), .rd_en(rd_en_np),
    .dout(np_dout), .empty(np_empty), .full(np_full), .count(np_count),
    .rx_done_tick(np_rx), .frame_err(np_fe), .parity_err(np_pe),
    .timeout_err(np_to), .overflow(np_ov));

  int chk_total = 0, chk_pass = 0;
  logic [7:0] rx_c = 0, fe_c = 0, pe_c = 0, to_c = 0, ov_c = 0, np_rx_c = 0;
  logic [7:0] exp_q[$];
  logic [47:0] base, got;

  always @(negedge clk) begin
    if (rx_done_tick) rx_c    <= rx_c + 8'd1;
    if (frame_err)    fe_c    <= fe_c + 8'd1;
    if (parity_err)   pe_c    <= pe_c + 8'd1;
    if (timeout_err)  to_c    <= to_c + 8'd1;
    if (overflow)     ov_c    <= ov_c + 8'd1;
    if (np_rx)        np_rx_c <= np_rx_c + 8'd1;
  end

  function automatic logic [47:0] cnts();
    return {rx_c, fe_c, pe_c, to_c, ov_c, np_rx_c};
  endfunction

  // one PS/2 bit: data settles, ps2c low 40 clk, high 40 clk; optional read aligned
  // with the CHECK cycle of the stop bit so push and pop coincide
  task automatic send_bit(input logic b, input bit coinc);
    logic [7:0] e;
    ps2d = b;
    repeat (20) @(negedge clk);
    ps2c = 1'b0;
    if (coinc) begin
      repeat (9) @(negedge clk);
      e = exp_q.pop_front();
      chk_total++;
      if (dout !== e || full !== 1'b1)
        $display("FAIL coinc_head got dout=%h full=%b exp dout=%h full=1", dout, full, e);
      else chk_pass++;
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      repeat (30) @(negedge clk);
    end else begin
      repeat (40) @(negedge clk);
    end
    ps2c = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input bit bad_par, input logic stop,
                            input int nbits, input bit coinc);
    logic [10:0] f;
    f = {stop, (~^data) ^ bad_par, data, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(f[i], coinc && (i == 10));
    ps2d = 1'b1;
  endtask

  task automatic do_read(input string name);
    logic [7:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    chk_total++;
    if (empty !== 1'b0 || dout !== e)
      $display("FAIL %s got empty=%b dout=%h exp empty=0 dout=%h", name, empty, dout, e);
    else chk_pass++;
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rd_en = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_total++;
    if ({empty, full, count, dout, rx_done_tick, frame_err, parity_err, timeout_err, overflow}
        !== {1'b1, 1'b0, 3'd0, 8'h00, 5'b0})
      $display("FAIL reset_state got e=%b f=%b c=%0d d=%h p=%b", empty, full, count, dout,
               {rx_done_tick, frame_err, parity_err, timeout_err, overflow});
    else chk_pass++;
    reset = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_good_frame();
    do_reset();
    base = cnts();
    exp_q.push_back(8'h1C);
    send_frame(8'h1C, 0, 1'b1, 11, 0);
    got = cnts() - base;
    chk_total++;
    if (got !== {8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1})
      $display("FAIL good_pulses got %h exp 010000000001", got);
    else chk_pass++;
    chk_total++;
    if (count !== 3'd1) $display("FAIL good_count got %0d exp 1", count);
    else chk_pass++;
    do_read("good_read");
    chk_total++;
    if (empty !== 1'b1 || dout !== 8'h00)
      $display("FAIL good_after_pop got empty=%b dout=%h exp 1 00", empty, dout);
    else chk_pass++;
  endtask

  task automatic test_parity();
    do_reset();
    base = cnts();
    send_frame(8'h1C, 1, 1'b1, 11, 0);
    got = cnts() - base;
    chk_total++;
    if (got !== {8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd1})
      $display("FAIL parity_pulses got %h exp 000001000001", got);
    else chk_pass++;
    chk_total++;
    if (empty !== 1'b1 || count !== 3'd0)
      $display("FAIL parity_fifo got empty=%b count=%0d exp 1 0", empty, count);
    else chk_pass++;
    chk_total++;
    if (np_empty !== 1'b0 || np_dout !== 8'h1C)
      $display("FAIL noparity_accept got empty=%b dout=%h exp 0 1c", np_empty, np_dout);
    else chk_pass++;
  endtask

  task automatic test_frame_err();
    do_reset();
    base = cnts();
    send_frame(8'h1C, 0, 1'b0, 11, 0);
    got = cnts() - base;
    chk_total++;
    if (got !== {8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0})
      $display("FAIL frame_pulses got %h exp 000100000000", got);
    else chk_pass++;
    chk_total++;
    if (empty !== 1'b1) $display("FAIL frame_nopush got empty=%b exp 1", empty);
    else chk_pass++;
    base = cnts();
    exp_q.push_back(8'hF0);
    send_frame(8'hF0, 0, 1'b1, 11, 0);
    got = cnts() - base;
    chk_total++;
    if (got[47:8] !== {8'd1, 8'd0, 8'd0, 8'd0, 8'd0})
      $display("FAIL frame_next_pulses got %h exp 0100000000", got[47:8]);
    else chk_pass++;
    do_read("frame_next_read");
  endtask

  task automatic test_timeout();
    do_reset();
    base = cnts();
    send_frame(8'hA5, 0, 1'b1, 6, 0);
    repeat (2100) @(negedge clk);
    got = cnts() - base;
    chk_total++;
    if (got[47:8] !== {8'd0, 8'd0, 8'd0, 8'd1, 8'd0})
      $display("FAIL timeout_pulses got %h exp 0000000100", got[47:8]);
    else chk_pass++;
    base = cnts();
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 0, 1'b1, 11, 0);
    got = cnts() - base;
    chk_total++;
    if (got[47:8] !== {8'd1, 8'd0, 8'd0, 8'd0, 8'd0})
      $display("FAIL timeout_next_pulses got %h exp 0100000000", got[47:8]);
    else chk_pass++;
    do_read("timeout_next_read");
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      base = cnts();
      if (i <= FD) exp_q.push_back(8'(i));
      send_frame(8'(i), 0, 1'b1, 11, 0);
      got = cnts() - base;
      chk_total++;
      if (got[47:8] !== ((i <= FD) ? {8'd1, 32'd0} : {32'd0, 8'd1}))
        $display("FAIL fill_pulses_%0d got %h", i, got[47:8]);
      else chk_pass++;
      if (i >= FD) begin
        chk_total++;
        if (full !== 1'b1 || count !== 3'd4)
          $display("FAIL fill_full_%0d got full=%b count=%0d exp 1 4", i, full, count);
        else chk_pass++;
      end
    end
    for (int i = 0; i < FD; i++) do_read("drain1");
    for (int i = 7; i <= 10; i++) begin
      exp_q.push_back(8'(i));
      send_frame(8'(i), 0, 1'b1, 11, 0);
    end
    base = cnts();
    exp_q.push_back(8'h0B);
    send_frame(8'h0B, 0, 1'b1, 11, 1);
    got = cnts() - base;
    chk_total++;
    if (got[47:8] !== {8'd1, 32'd0})
      $display("FAIL coinc_pulses got %h exp 0100000000", got[47:8]);
    else chk_pass++;
    chk_total++;
    if (count !== 3'd4 || full !== 1'b1)
      $display("FAIL coinc_count got count=%0d full=%b exp 4 1", count, full);
    else chk_pass++;
    for (int i = 0; i < FD; i++) do_read("drain2");
    chk_total++;
    if (empty !== 1'b1 || count !== 3'd0)
      $display("FAIL drain_empty got empty=%b count=%0d exp 1 0", empty, count);
    else chk_pass++;
  endtask

  task automatic test_glitch();
    do_reset();
    base = cnts();
    ps2d = 1'b0;
    repeat (10) @(negedge clk);
    ps2c = 1'b0;
    repeat (3) @(negedge clk);
    ps2c = 1'b1;
    repeat (50) @(negedge clk);
    ps2d = 1'b1;
    repeat (20) @(negedge clk);
    exp_q.push_back(8'h33);
    send_frame(8'h33, 0, 1'b1, 11, 0);
    got = cnts() - base;
    chk_total++;
    if (got[47:8] !== {8'd1, 32'd0})
      $display("FAIL glitch_pulses got %h exp 0100000000", got[47:8]);
    else chk_pass++;
    do_read("glitch_read");
  endtask

  task automatic test_rx_en();
    do_reset();
    rx_en = 1'b0;
    base = cnts();
    send_frame(8'hC3, 0, 1'b1, 11, 0);
    got = cnts() - base;
    chk_total++;
    if (got !== 48'd0 || empty !== 1'b1)
      $display("FAIL rx_en_ignore got pulses=%h empty=%b exp 0 1", got, empty);
    else chk_pass++;
    rx_en = 1'b1;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 0, 1'b1, 11, 0);
    do_read("rx_en_read");
  endtask

  task automatic test_reset_mid();
    do_reset();
    exp_q.push_back(8'h1C);
    send_frame(8'h1C, 0, 1'b1, 11, 0);
    base = cnts();
    send_frame(8'h77, 0, 1'b1, 4, 0);
    reset = 1'b1;
    @(negedge clk);
    chk_total++;
    if ({empty, full, count, dout, rx_done_tick, frame_err, parity_err, timeout_err, overflow}
        !== {1'b1, 1'b0, 3'd0, 8'h00, 5'b0})
      $display("FAIL midreset_state got e=%b c=%0d d=%h", empty, count, dout);
    else chk_pass++;
    reset = 1'b0;
    exp_q.delete();
    repeat (2200) @(negedge clk);
    got = cnts() - base;
    chk_total++;
    if (got !== 48'd0) $display("FAIL midreset_pulses got %h exp 0", got);
    else chk_pass++;
    base = cnts();
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 0, 1'b1, 11, 0);
    got = cnts() - base;
    chk_total++;
    if (got[47:8] !== {8'd1, 32'd0})
      $display("FAIL midreset_next_pulses got %h exp 0100000000", got[47:8]);
    else chk_pass++;
    do_read("midreset_read");
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_good_frame();
    test_parity();
    test_frame_err();
    test_timeout();
    test_overflow();
    test_glitch();
    test_rx_en();
    test_reset_mid();
    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end
endmodule
